// File: rtl/vault_flash_if_pkg.sv
// Shared types and constants for the vault flash interface and its storage array.
package vault_flash_if_pkg;

    localparam int unsigned ADDR_WIDTH  = 4;
    localparam int unsigned DATA_WIDTH  = 256;
    localparam int unsigned NUM_ENTRIES = 1 << ADDR_WIDTH;

    // Entry word layout: accumulator field low, pass field high.
    localparam int unsigned FIELD_WIDTH = 128;
    localparam int unsigned ACC_LSB     = 0;
    localparam int unsigned PASS_LSB    = 128;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_WAIT   = 3'd1,
        PROG      = 3'd2,
        BOOT_RD   = 3'd3,
        BOOT_LOAD = 3'd4,
        BOOT_NEXT = 3'd5,
        DONE      = 3'd6
    } state_e;

    // One slot of the array read pipeline.
    typedef struct packed {
        logic                  hit;
        logic [DATA_WIDTH-1:0] data;
    } rd_word_t;

endpackage

// File: rtl/vault_flash_array.sv
// 16-entry storage with per-entry valid bits and a READ_CYCLES-deep read pipeline.
// Data is never reset; valid bits clear on rst or on a clear request.
module vault_flash_array
    import vault_flash_if_pkg::*;
#(
    parameter int unsigned READ_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_hit,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0]  mem_q   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  mem_d   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] valid_d;
    rd_word_t               pipe_q  [READ_CYCLES];
    rd_word_t               pipe_d  [READ_CYCLES];
    rd_word_t               lookup_c;

    // Next array contents: both entry fields stored as given, valid set on write, cleared on erase.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (wr_en) begin
            mem_d[wr_addr][PASS_LSB +: FIELD_WIDTH] = wr_data[PASS_LSB +: FIELD_WIDTH];
            mem_d[wr_addr][ACC_LSB +: FIELD_WIDTH]  = wr_data[ACC_LSB +: FIELD_WIDTH];
            valid_d[wr_addr] = 1'b1;
        end
        if (clr_en) begin
            valid_d[clr_addr] = 1'b0;
        end
    end

    // Read lookup feeds the pipeline; invalid entries read back as zero.
    always_comb begin
        lookup_c.hit  = valid_q[rd_addr];
        lookup_c.data = valid_q[rd_addr] ? mem_q[rd_addr] : '0;
        pipe_d[0]     = rd_en ? lookup_c : '0;
        for (int unsigned i = 1; i < READ_CYCLES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Storage data is left unreset on purpose.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Valid bits and read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < READ_CYCLES; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned i = 0; i < READ_CYCLES; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign rd_hit  = pipe_q[READ_CYCLES-1].hit;
    assign rd_data = pipe_q[READ_CYCLES-1].data;

endmodule

// File: rtl/vault_flash_if.sv
// Vault flash interface: read/program handshakes and boot-time replay of the
// accumulator field of every valid entry into an external CAM.
// Optional erase port enabled by defining VAULT_ERASE_EN.
module vault_flash_if
    import vault_flash_if_pkg::*;
#(
    parameter int unsigned READ_CYCLES = 2,
    parameter int unsigned PROG_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic                   wr_req,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_req,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
`ifdef VAULT_ERASE_EN
    input  logic                   er_req,
    input  logic [ADDR_WIDTH-1:0]  er_addr,
`endif
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   rd_hit,
    input  logic                   boot_start,
    output logic                   boot_busy,
    output logic                   boot_done,
    output logic                   cam_we,
    output logic [ADDR_WIDTH-1:0]  cam_waddr,
    output logic [FIELD_WIDTH-1:0] cam_din
);

    localparam int unsigned MAX_CYCLES = (PROG_CYCLES > READ_CYCLES) ? PROG_CYCLES : READ_CYCLES;
    localparam int unsigned CNT_WIDTH  = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0]  RD_LOAD   = CNT_WIDTH'(READ_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  PROG_LOAD = CNT_WIDTH'(PROG_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_ENTRIES - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic                   ready_q, ready_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                   rd_hit_q, rd_hit_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   boot_busy_q, boot_busy_d;
    logic                   boot_done_q, boot_done_d;
    logic                   cam_we_q, cam_we_d;
    logic [ADDR_WIDTH-1:0]  cam_waddr_q, cam_waddr_d;
    logic [FIELD_WIDTH-1:0] cam_din_q, cam_din_d;

    logic                   arr_wr_en_c;
    logic                   arr_clr_en_c;
    logic                   arr_rd_en_c;
    logic [ADDR_WIDTH-1:0]  arr_rd_addr_c;
    logic                   arr_hit;
    logic [DATA_WIDTH-1:0]  arr_data;
    logic                   erase_req_c;
    logic [ADDR_WIDTH-1:0]  erase_addr_c;

`ifdef VAULT_ERASE_EN
    assign erase_req_c  = er_req;
    assign erase_addr_c = er_addr;
`else
    assign erase_req_c  = 1'b0;
    assign erase_addr_c = '0;
`endif

    vault_flash_array #(
        .READ_CYCLES (READ_CYCLES)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (arr_wr_en_c),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_en   (arr_clr_en_c),
        .clr_addr (erase_addr_c),
        .rd_en    (arr_rd_en_c),
        .rd_addr  (arr_rd_addr_c),
        .rd_hit   (arr_hit),
        .rd_data  (arr_data)
    );

    // Next-state, array control and registered-output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        rd_data_d     = rd_data_q;
        rd_hit_d      = rd_hit_q;
        rd_valid_d    = 1'b0;
        cam_waddr_d   = '0;
        cam_din_d     = '0;
        arr_wr_en_c   = 1'b0;
        arr_clr_en_c  = 1'b0;
        arr_rd_en_c   = 1'b0;
        arr_rd_addr_c = '0;

        unique case (state_q)
            IDLE: begin
                // Single winner per cycle; losing requests are simply dropped.
                if (!rst) begin
                    if (boot_start) begin
                        state_d       = BOOT_RD;
                        cnt_d         = RD_LOAD;
                        idx_d         = '0;
                        arr_rd_en_c   = 1'b1;
                        arr_rd_addr_c = '0;
                    end else if (erase_req_c) begin
                        state_d      = PROG;
                        cnt_d        = PROG_LOAD;
                        arr_clr_en_c = 1'b1;
                    end else if (wr_req) begin
                        state_d     = PROG;
                        cnt_d       = PROG_LOAD;
                        arr_wr_en_c = 1'b1;
                    end else if (rd_req) begin
                        state_d       = RD_WAIT;
                        cnt_d         = RD_LOAD;
                        arr_rd_en_c   = 1'b1;
                        arr_rd_addr_c = rd_addr;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b1;
                    rd_hit_d   = arr_hit;
                    rd_data_d  = arr_data;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            PROG: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            BOOT_RD: begin
                if (cnt_q == '0) begin
                    if (arr_hit) begin
                        state_d     = BOOT_LOAD;
                        cam_waddr_d = idx_q;
                        cam_din_d   = arr_data[ACC_LSB +: FIELD_WIDTH];
                    end else begin
                        state_d = BOOT_NEXT;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            BOOT_LOAD: begin
                state_d = BOOT_NEXT;
            end
            BOOT_NEXT: begin
                // Wrapping past the last entry ends the replay.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    state_d       = BOOT_RD;
                    cnt_d         = RD_LOAD;
                    idx_d         = idx_q + ADDR_WIDTH'(1);
                    arr_rd_en_c   = 1'b1;
                    arr_rd_addr_c = idx_q + ADDR_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d     = (state_d == IDLE);
        cam_we_d    = (state_d == BOOT_LOAD);
        boot_done_d = (state_d == DONE);
        boot_busy_d = (state_d == BOOT_RD) || (state_d == BOOT_LOAD) || (state_d == BOOT_NEXT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            ready_q     <= 1'b1;
            rd_data_q   <= '0;
            rd_hit_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            boot_busy_q <= 1'b0;
            boot_done_q <= 1'b0;
            cam_we_q    <= 1'b0;
            cam_waddr_q <= '0;
            cam_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ready_q     <= ready_d;
            rd_data_q   <= rd_data_d;
            rd_hit_q    <= rd_hit_d;
            rd_valid_q  <= rd_valid_d;
            boot_busy_q <= boot_busy_d;
            boot_done_q <= boot_done_d;
            cam_we_q    <= cam_we_d;
            cam_waddr_q <= cam_waddr_d;
            cam_din_q   <= cam_din_d;
        end
    end

    assign ready     = ready_q;
    assign rd_data   = rd_data_q;
    assign rd_hit    = rd_hit_q;
    assign rd_valid  = rd_valid_q;
    assign boot_busy = boot_busy_q;
    assign boot_done = boot_done_q;
    assign cam_we    = cam_we_q;
    assign cam_waddr = cam_waddr_q;
    assign cam_din   = cam_din_q;

endmodule

// File: tb/tb_vault_flash_if.sv
// Directed bench for vault_flash_if: read latency, program busy time, request
// priority, boot replay into the CAM, reset mid-boot, and erase when VAULT_ERASE_EN is defined.
module tb_vault_flash_if;
    import vault_flash_if_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ready;
    logic                   wr_req;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   rd_req;
    logic [ADDR_WIDTH-1:0]  rd_addr;
`ifdef VAULT_ERASE_EN
    logic                   er_req;
    logic [ADDR_WIDTH-1:0]  er_addr;
`endif
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_valid;
    logic                   rd_hit;
    logic                   boot_start;
    logic                   boot_busy;
    logic                   boot_done;
    logic                   cam_we;
    logic [ADDR_WIDTH-1:0]  cam_waddr;
    logic [FIELD_WIDTH-1:0] cam_din;

    int errors = 0;
    int checks = 0;

    vault_flash_if dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
`ifdef VAULT_ERASE_EN
        .er_req     (er_req),
        .er_addr    (er_addr),
`endif
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_hit     (rd_hit),
        .boot_start (boot_start),
        .boot_busy  (boot_busy),
        .boot_done  (boot_done),
        .cam_we     (cam_we),
        .cam_waddr  (cam_waddr),
        .cam_din    (cam_din)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [DATA_WIDTH-1:0] obs, input logic [DATA_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && !ready; i++) tick();
        check1(tag, ready, 1'b1);
    endtask

    task automatic do_write(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
        wait_ready("write_ready");
    endtask

    // rd_req driven in cycle c; rd_valid must appear in cycle c+3 only.
    task automatic do_read(input string tag, input logic [ADDR_WIDTH-1:0] a,
                           input logic exp_hit, input logic [DATA_WIDTH-1:0] exp_data);
        rd_addr = a;
        rd_req  = 1'b1;
        tick();
        rd_req  = 1'b0;
        check1({tag, "_valid_c1"}, rd_valid, 1'b0);
        tick();
        check1({tag, "_valid_c2"}, rd_valid, 1'b0);
        tick();
        check1({tag, "_valid_c3"}, rd_valid, 1'b1);
        check1({tag, "_hit"}, rd_hit, exp_hit);
        checkw({tag, "_data"}, rd_data, exp_data);
        tick();
        check1({tag, "_valid_c4"}, rd_valid, 1'b0);
    endtask

    localparam logic [DATA_WIDTH-1:0] W3  = {128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5,
                                             128'h01234567_89ABCDEF_01234567_89ABCDEF};
    localparam logic [DATA_WIDTH-1:0] W3B = {128'h11112222_33334444_55556666_77778888,
                                             128'h99990000_AAAABBBB_CCCCDDDD_EEEEFFFF};
    localparam logic [DATA_WIDTH-1:0] W9  = {128'hDEADBEEF_00000000_00000000_CAFEF00D,
                                             128'h00000000_00000009_00000000_00000009};
    localparam logic [DATA_WIDTH-1:0] D0  = {128'hF0F0F0F0_F0F0F0F0_F0F0F0F0_F0F0F0F0,
                                             128'h00000000_00000000_00000000_0000A000};
    localparam logic [DATA_WIDTH-1:0] D5  = {128'hE5E5E5E5_E5E5E5E5_E5E5E5E5_E5E5E5E5,
                                             128'h00000000_00000000_00000000_0000A005};
    localparam logic [DATA_WIDTH-1:0] D15 = {128'hCFCFCFCF_CFCFCFCF_CFCFCFCF_CFCFCFCF,
                                             128'h00000000_00000000_00000000_0000A00F};
    localparam logic [DATA_WIDTH-1:0] ZERO = '0;

    logic [ADDR_WIDTH-1:0]  we_addr [4];
    logic [FIELD_WIDTH-1:0] we_din  [4];
    int                     n_we;
    int                     n_done;
    int                     bad_idle;
    int                     n_low;
    int                     n_rv;
    logic                   busy_at_done;

    initial begin
        rst        = 1'b1;
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        boot_start = 1'b0;
`ifdef VAULT_ERASE_EN
        er_req     = 1'b0;
        er_addr    = '0;
`endif
        tick();
        tick();

        // Reset state.
        check1("rst_ready", ready, 1'b1);
        check1("rst_rd_valid", rd_valid, 1'b0);
        check1("rst_rd_hit", rd_hit, 1'b0);
        checkw("rst_rd_data", rd_data, ZERO);
        check1("rst_boot_busy", boot_busy, 1'b0);
        check1("rst_boot_done", boot_done, 1'b0);
        check1("rst_cam_we", cam_we, 1'b0);
        rst = 1'b0;
        tick();

        // Read of an unwritten entry after reset.
        do_read("rd7_empty", 4'd7, 1'b0, ZERO);

        // Write then read back addr 3.
        do_write(4'd3, W3);
        do_read("rd3", 4'd3, 1'b1, W3);

        // Simultaneous write and read: write wins, read dropped; requests during PROG ignored.
        wr_addr = 4'd9;
        wr_data = W9;
        wr_req  = 1'b1;
        rd_addr = 4'd3;
        rd_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_addr = 4'd10;
        n_low   = 0;
        n_rv    = 0;
        for (int i = 0; i < 12; i++) begin
            if (!ready) n_low++;
            if (rd_valid) n_rv++;
            wr_req = (i == 2);
            tick();
        end
        wr_req = 1'b0;
        checkn("collide_ready_low_cycles", n_low, 8);
        checkn("collide_rd_valid_count", n_rv, 0);
        do_read("rd9_written", 4'd9, 1'b1, W9);
        do_read("rd10_ignored", 4'd10, 1'b0, ZERO);

        // Overwrite the same address.
        do_write(4'd3, W3B);
        do_read("rd3_overwrite", 4'd3, 1'b1, W3B);

        // Reset clears valid bits.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_read("rd3_after_rst", 4'd3, 1'b0, ZERO);

        // Boot replay of entries 0, 5, 15; a simultaneous write to 7 loses to boot_start.
        do_write(4'd0, D0);
        do_write(4'd5, D5);
        do_write(4'd15, D15);
        boot_start = 1'b1;
        wr_req     = 1'b1;
        wr_addr    = 4'd7;
        wr_data    = W9;
        tick();
        boot_start = 1'b0;
        wr_req     = 1'b0;
        check1("boot_busy_on", boot_busy, 1'b1);
        check1("boot_ready_low", ready, 1'b0);
        n_we         = 0;
        n_done       = 0;
        bad_idle     = 0;
        busy_at_done = 1'b1;
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            if (cam_we) begin
                if (n_we < 4) begin
                    we_addr[n_we] = cam_waddr;
                    we_din[n_we]  = cam_din;
                end
                n_we++;
            end else if (cam_waddr != '0 || cam_din != '0) begin
                bad_idle++;
            end
            if (boot_done) begin
                n_done++;
                busy_at_done = boot_busy;
            end
            tick();
        end
        checkn("boot_cam_we_count", n_we, 3);
        checkn("boot_waddr0", int'(we_addr[0]), 0);
        checkn("boot_waddr1", int'(we_addr[1]), 5);
        checkn("boot_waddr2", int'(we_addr[2]), 15);
        checkw("boot_din0", DATA_WIDTH'(we_din[0]), DATA_WIDTH'(D0[127:0]));
        checkw("boot_din1", DATA_WIDTH'(we_din[1]), DATA_WIDTH'(D5[127:0]));
        checkw("boot_din2", DATA_WIDTH'(we_din[2]), DATA_WIDTH'(D15[127:0]));
        checkn("boot_idle_port_nonzero", bad_idle, 0);
        checkn("boot_done_seen", n_done, 1);
        check1("boot_busy_at_done", busy_at_done, 1'b0);
        check1("boot_done_pulse_end", boot_done, 1'b0);
        check1("boot_busy_after", boot_busy, 1'b0);
        check1("boot_ready_after", ready, 1'b1);
        do_read("rd7_dropped", 4'd7, 1'b0, ZERO);
        do_read("rd5_kept", 4'd5, 1'b1, D5);
        tick();
        tick();
        tick();
        checkw("rd_data_held", rd_data, D5);

        // Reset in the middle of a boot, right after the first CAM load.
        boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
        for (int i = 0; i < 50 && !cam_we; i++) tick();
        check1("midboot_first_we", cam_we, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("midboot_ready", ready, 1'b1);
        check1("midboot_cam_we", cam_we, 1'b0);
        check1("midboot_busy", boot_busy, 1'b0);
        check1("midboot_done", boot_done, 1'b0);
        n_we   = 0;
        n_done = 0;
        for (int i = 0; i < 100; i++) begin
            if (cam_we) n_we++;
            if (boot_done) n_done++;
            tick();
        end
        checkn("midboot_later_we", n_we, 0);
        checkn("midboot_later_done", n_done, 0);
        do_read("rd5_after_midboot", 4'd5, 1'b0, ZERO);

`ifdef VAULT_ERASE_EN
        // Erase beats a concurrent write and clears the valid bit.
        do_write(4'd2, W3);
        do_read("rd2_before_erase", 4'd2, 1'b1, W3);
        er_addr = 4'd2;
        er_req  = 1'b1;
        wr_addr = 4'd2;
        wr_data = W9;
        wr_req  = 1'b1;
        tick();
        er_req  = 1'b0;
        wr_req  = 1'b0;
        n_low   = 0;
        for (int i = 0; i < 12; i++) begin
            if (!ready) n_low++;
            tick();
        end
        checkn("erase_ready_low_cycles", n_low, 8);
        do_read("rd2_erased", 4'd2, 1'b0, ZERO);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vault_flash_if.md
VAULT_FLASH_IF -- requirements
Module: vault_flash_if

Interface
REQ-001 Parameters: ADDR_WIDTH, 4, entry address width (16 entries); DATA_WIDTH, 256, entry width; READ_CYCLES, 2, array read latency; PROG_CYCLES, 8, program busy time.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ready  out  1  high only in IDLE; a request is accepted only on a cycle with ready=1.
REQ-006 wr_req  in  1  one-cycle program request.
REQ-007 wr_addr  in  ADDR_WIDTH  entry to program.
REQ-008 wr_data  in  DATA_WIDTH  entry word; [255:128] and [127:0] stored unmodified.
REQ-009 rd_req  in  1  one-cycle read request.
REQ-010 rd_addr  in  ADDR_WIDTH  entry to read.
REQ-011 rd_data  out  DATA_WIDTH  read word, held until the next read completes.
REQ-012 rd_valid  out  1  one-cycle pulse, rd_data/rd_hit valid.
REQ-013 rd_hit  out  1  entry valid bit at read time.
REQ-014 boot_start  in  1  start full-array replay into the CAM.
REQ-015 boot_busy  out  1  high from acceptance until boot_done.
REQ-016 boot_done  out  1  one-cycle pulse at end of replay.
REQ-017 cam_we / cam_waddr / cam_din  out  1 / ADDR_WIDTH / 128  CAM load port.

Function
REQ-018 FSM states: IDLE, RD_WAIT, PROG, BOOT_RD, BOOT_LOAD, BOOT_NEXT, DONE.
REQ-019 Priority when several requests are asserted with ready=1: boot_start > wr_req > rd_req; losers are dropped, not queued.
REQ-020 Requests while ready=0 are ignored with no side effect.
REQ-021 Read: IDLE->RD_WAIT for READ_CYCLES cycles; rd_valid pulses READ_CYCLES+1 cycles after acceptance; then IDLE.
REQ-022 Read of an invalid entry: rd_data=0, rd_hit=0, rd_valid still pulses.
REQ-023 Program: word written and valid bit set on the acceptance edge; PROG held PROG_CYCLES cycles, then IDLE; rewriting the same address overwrites.
REQ-024 Boot: index 0..15 in order; per index BOOT_RD takes READ_CYCLES cycles, then for valid entries BOOT_LOAD asserts cam_we for exactly one cycle with cam_waddr=index and cam_din=word[127:0]; invalid entries are skipped without cam_we.
REQ-025 Index wrap 15->0 ends the replay: DONE pulses boot_done for one cycle, clears boot_busy, returns to IDLE.
REQ-026 cam_we is never asserted outside BOOT_LOAD; cam_din/cam_waddr are 0 when cam_we=0.

Reset
REQ-027 rst in any state -> IDLE next edge; ready=1; rd_data=0; rd_valid, rd_hit, boot_busy, boot_done, cam_we=0; all valid bits cleared; an interrupted program or boot is abandoned.
REQ-028 The storage array data is not reset.

Configuration
REQ-029 VAULT_ERASE_EN defined: ports er_req (in 1) and er_addr (in ADDR_WIDTH) exist; an erase is accepted like a write, has priority between boot_start and wr_req, clears the valid bit, and occupies PROG for PROG_CYCLES cycles.
REQ-030 VAULT_ERASE_EN undefined: no erase ports; valid bits clear only on rst.

Structure
REQ-031 Shared package holds the FSM state enum, ADDR_WIDTH, DATA_WIDTH, and the entry field slice constants (ACC_LSB=0, PASS_LSB=128).
REQ-032 One sub-module, vault_flash_array: 16xDATA_WIDTH storage plus valid bits with a READ_CYCLES read pipeline; FSM and handshakes stay in vault_flash_if.

Verification
REQ-033 Write addr 3 = {128'hA5.., 128'h0123..}, wait ready, read addr 3 -> rd_valid 3 cycles after rd_req, rd_hit=1, rd_data equal to written word.
REQ-034 After reset, read addr 7 -> rd_data=0, rd_hit=0, rd_valid one pulse.
REQ-035 wr_req and rd_req in the same cycle -> write performed, read dropped, ready low for 8 cycles, no rd_valid.
REQ-036 Program addrs 0, 5, 15, boot_start -> exactly three cam_we pulses, waddr 0, 5, 15 in order, cam_din = word[127:0], then one boot_done pulse and boot_busy low.
REQ-037 rst asserted mid-boot after the first cam_we -> IDLE next cycle, no further cam_we, no boot_done, subsequent read of addr 5 returns rd_hit=0.
REQ-038 VAULT_ERASE_EN: write addr 2, erase addr 2, read addr 2 -> rd_hit=0, rd_data=0.
